// File: rtl/isp_top.sv
// isp_top -- raw Bayer (RGGB) front end.
//
// Accepts a raster stream of raw samples, one per valid_in beat, and either
// re-emits every sample tagged with its Bayer colour (BYPASS) or bins every
// 2x2 quad into one RGB pixel emitted serially as R, G, B (DEMOSAIC).
//
// Ports:
//   clk               rising-edge clock
//   rst_n             synchronous active-low reset
//   pixel_in          raw sample
//   valid_in          sample strobe
//   color_in          unused, source drives VOID
//   last_col_in       last sample of a raw row
//   last_pic_in       last sample of the picture
//   mode_in           0 = BYPASS, 1 = DEMOSAIC, others behave as BYPASS
//   pixel_out         output sample (0 when valid_out is low)
//   valid_out         output strobe
//   color_out         colour tag: VOID=0, RED=1, GREEN=2, BLUE=3
//   last_col_out      last output sample of an output row
//   last_pic_out      last output sample of the picture
//   finish_operation  picture completely emitted (high while in DONE)
module isp_top #(
  parameter int COLOR_DEPTH   = 8,
  parameter int COLOR_BIT_CNT = 2,
  parameter int MODE_BIT_CNT  = 3,
  parameter int IMG_COL       = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COLOR_DEPTH-1:0]   pixel_in,
  input  logic                     valid_in,
  input  logic [COLOR_BIT_CNT-1:0] color_in,
  input  logic                     last_col_in,
  input  logic                     last_pic_in,
  input  logic [MODE_BIT_CNT-1:0]  mode_in,
  output logic [COLOR_DEPTH-1:0]   pixel_out,
  output logic                     valid_out,
  output logic [COLOR_BIT_CNT-1:0] color_out,
  output logic                     last_col_out,
  output logic                     last_pic_out,
  output logic                     finish_operation
);

  localparam int CW = $clog2(IMG_COL);

  localparam logic [COLOR_BIT_CNT-1:0] C_VOID  = COLOR_BIT_CNT'(0);
  localparam logic [COLOR_BIT_CNT-1:0] C_RED   = COLOR_BIT_CNT'(1);
  localparam logic [COLOR_BIT_CNT-1:0] C_GREEN = COLOR_BIT_CNT'(2);
  localparam logic [COLOR_BIT_CNT-1:0] C_BLUE  = COLOR_BIT_CNT'(3);
  localparam logic [MODE_BIT_CNT-1:0]  M_DEMOSAIC = MODE_BIT_CNT'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // The colour tag input carries no information.
  logic unused_color;
  assign unused_color = ^color_in;

  state_t                   state_reg, state_next;
  logic [MODE_BIT_CNT-1:0]  mode_reg, mode_next;
  logic [CW-1:0]            col_reg, col_next;
  logic                     row_odd_reg, row_odd_next;
  logic [1:0]               phase_reg, phase_next;   // serializer: 0 idle, 1 emit G, 2 emit B
  logic [COLOR_DEPTH-1:0]   g2_reg, g2_next;
  logic [COLOR_DEPTH-1:0]   b_hold_reg, b_hold_next;
  logic                     lc_hold_reg, lc_hold_next;
  logic                     lp_hold_reg, lp_hold_next;
  logic                     ghost_reg, ghost_next;   // picture ended without a final BLUE

  logic [COLOR_DEPTH-1:0]   pixel_out_reg, pixel_out_next;
  logic                     valid_out_reg, valid_out_next;
  logic [COLOR_BIT_CNT-1:0] color_out_reg, color_out_next;
  logic                     last_col_out_reg, last_col_out_next;
  logic                     last_pic_out_reg, last_pic_out_next;

  // Line buffer holding the previous even row, plus its registered read port.
  logic [COLOR_DEPTH-1:0]   line_buf [IMG_COL];
  logic [COLOR_DEPTH-1:0]   rd_reg;

  // Position/mode as seen by the current beat: a beat that starts a new
  // picture sees cleared counters and the freshly presented mode.
  logic                     start;
  logic [CW-1:0]            col_eff;
  logic                     odd_eff;
  logic [MODE_BIT_CNT-1:0]  mode_eff;
  logic                     demosaic;
  logic                     buf_wr;
  logic                     buf_rd;
  logic [COLOR_DEPTH:0]     g_sum;
  logic [COLOR_DEPTH-1:0]   g_avg;

  always_comb begin
    start    = valid_in && (state_reg != RUN);
    col_eff  = start ? '0 : col_reg;
    odd_eff  = start ? 1'b0 : row_odd_reg;
    mode_eff = start ? mode_in : mode_reg;
    demosaic = (mode_eff == M_DEMOSAIC);
    buf_wr   = valid_in && demosaic && !odd_eff;
    buf_rd   = valid_in && demosaic && odd_eff;
    // rd_reg holds buf[c] (G1) while the serializer emits GREEN.
    g_sum    = {1'b0, rd_reg} + {1'b0, g2_reg} + (COLOR_DEPTH+1)'(1);
    g_avg    = COLOR_DEPTH'(g_sum >> 1);
  end

  // Even-row writes and odd-row reads never coincide. On the odd row the G2
  // beat reads buf[c-1] (R); the B beat reads buf[c] (G1) while R leaves.
  always_ff @(posedge clk) begin
    if (buf_wr) line_buf[col_eff] <= pixel_in;
    if (buf_rd) rd_reg <= line_buf[col_eff];
  end

  always_comb begin
    state_next        = state_reg;
    mode_next         = mode_reg;
    col_next          = col_reg;
    row_odd_next      = row_odd_reg;
    phase_next        = phase_reg;
    g2_next           = g2_reg;
    b_hold_next       = b_hold_reg;
    lc_hold_next      = lc_hold_reg;
    lp_hold_next      = lp_hold_reg;
    ghost_next        = 1'b0;
    pixel_out_next    = '0;
    valid_out_next    = 1'b0;
    color_out_next    = C_VOID;
    last_col_out_next = 1'b0;
    last_pic_out_next = 1'b0;

    case (state_reg)
      IDLE:    if (valid_in) state_next = RUN;
      RUN:     if (last_pic_out_reg || ghost_reg) state_next = DONE;
      DONE:    if (valid_in) state_next = RUN;
      default: state_next = IDLE;
    endcase

    // Serializer tail for a quad started on an earlier B beat.
    case (phase_reg)
      2'd1: begin
        valid_out_next = 1'b1;
        pixel_out_next = g_avg;
        color_out_next = C_GREEN;
        phase_next     = 2'd2;
      end
      2'd2: begin
        valid_out_next    = 1'b1;
        pixel_out_next    = b_hold_reg;
        color_out_next    = C_BLUE;
        last_col_out_next = lc_hold_reg;
        last_pic_out_next = lp_hold_reg;
        phase_next        = 2'd0;
      end
      default: ;
    endcase

    if (valid_in) begin
      mode_next = mode_eff;
      // End of picture also rewinds position, so a truncated row cannot
      // leak into the next picture.
      if (last_col_in || last_pic_in) col_next = '0;
      else                            col_next = col_eff + CW'(1);
      if (last_pic_in)      row_odd_next = 1'b0;
      else if (last_col_in) row_odd_next = !odd_eff;
      else                  row_odd_next = odd_eff;

      if (!demosaic) begin
        valid_out_next    = 1'b1;
        pixel_out_next    = pixel_in;
        last_col_out_next = last_col_in;
        last_pic_out_next = last_pic_in;
        case ({odd_eff, col_eff[0]})
          2'b00:   color_out_next = C_RED;
          2'b11:   color_out_next = C_BLUE;
          default: color_out_next = C_GREEN;
        endcase
      end else if (odd_eff && col_eff[0]) begin
        // B sample: emit R now, G and B on the next two cycles.
        valid_out_next = 1'b1;
        pixel_out_next = rd_reg;
        color_out_next = C_RED;
        phase_next     = 2'd1;
        b_hold_next    = pixel_in;
        lc_hold_next   = last_col_in;
        lp_hold_next   = last_pic_in;
      end else begin
        if (odd_eff) g2_next = pixel_in;
        // A picture ending here will never produce a flagged BLUE.
        ghost_next = last_pic_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      mode_reg         <= '0;
      col_reg          <= '0;
      row_odd_reg      <= 1'b0;
      phase_reg        <= 2'd0;
      g2_reg           <= '0;
      b_hold_reg       <= '0;
      lc_hold_reg      <= 1'b0;
      lp_hold_reg      <= 1'b0;
      ghost_reg        <= 1'b0;
      pixel_out_reg    <= '0;
      valid_out_reg    <= 1'b0;
      color_out_reg    <= C_VOID;
      last_col_out_reg <= 1'b0;
      last_pic_out_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      mode_reg         <= mode_next;
      col_reg          <= col_next;
      row_odd_reg      <= row_odd_next;
      phase_reg        <= phase_next;
      g2_reg           <= g2_next;
      b_hold_reg       <= b_hold_next;
      lc_hold_reg      <= lc_hold_next;
      lp_hold_reg      <= lp_hold_next;
      ghost_reg        <= ghost_next;
      pixel_out_reg    <= pixel_out_next;
      valid_out_reg    <= valid_out_next;
      color_out_reg    <= color_out_next;
      last_col_out_reg <= last_col_out_next;
      last_pic_out_reg <= last_pic_out_next;
    end
  end

  assign pixel_out        = pixel_out_reg;
  assign valid_out        = valid_out_reg;
  assign color_out        = color_out_reg;
  assign last_col_out     = last_col_out_reg;
  assign last_pic_out     = last_pic_out_reg;
  assign finish_operation = (state_reg == DONE);

endmodule

// File: tb/tb_isp_top.sv
// Scoreboard bench for isp_top with a 4-column image. Stimulus pushes the
// hand-computed expected outputs (value, tag, flags, cycle) into a queue; a
// monitor on the falling edge pops and compares every valid output and
// checks that idle outputs are all zero.
module tb_isp_top;
  localparam int W = 8;
  localparam int CB = 2;
  localparam int MB = 3;
  localparam int COLS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  pixel_in;
  logic          valid_in;
  logic [CB-1:0] color_in;
  logic          last_col_in;
  logic          last_pic_in;
  logic [MB-1:0] mode_in;
  logic [W-1:0]  pixel_out;
  logic          valid_out;
  logic [CB-1:0] color_out;
  logic          last_col_out;
  logic          last_pic_out;
  logic          finish_operation;

  always #5 clk = ~clk;

  isp_top #(.COLOR_DEPTH(W), .COLOR_BIT_CNT(CB), .MODE_BIT_CNT(MB), .IMG_COL(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in),
    .color_in(color_in), .last_col_in(last_col_in), .last_pic_in(last_pic_in),
    .mode_in(mode_in), .pixel_out(pixel_out), .valid_out(valid_out),
    .color_out(color_out), .last_col_out(last_col_out), .last_pic_out(last_pic_out),
    .finish_operation(finish_operation)
  );

  typedef struct packed {
    logic [7:0]  pix;
    logic [1:0]  col;
    logic        lc;
    logic        lp;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Bayer tags of a 4x2 raster in bypass: R G R G / G B G B.
  localparam logic [1:0] BYP_COL [8] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3, 2'd2, 2'd3};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic expect_out(input logic [7:0] p, input logic [1:0] c, input logic lc,
                            input logic lp, input int at);
    exp_t x;
    x.pix = p; x.col = c; x.lc = lc; x.lp = lp; x.cyc = 32'(at);
    sb.push_back(x);
  endtask

  // Monitor: one line per output transaction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out) begin
        $display("out cyc=%0d pix=%0d color=%0d last_col=%0d last_pic=%0d",
                 cyc, pixel_out, color_out, last_col_out, last_pic_out);
        check("output_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("out_pix_col_lc_lp_cyc",
                {20'd0, pixel_out, color_out, last_col_out, last_pic_out, 32'(cyc)},
                {20'd0, e.pix, e.col, e.lc, e.lp, e.cyc});
        end
      end else begin
        check("idle_outputs", 64'({pixel_out, color_out, last_col_out, last_pic_out}), 64'd0);
      end
    end
  end

  // Drive one beat on a falling edge; e is the cycle index after its capture edge.
  task automatic beat_start(input logic [7:0] p, input logic [2:0] md, input logic lc,
                            input logic lp, output int e);
    @(negedge clk);
    pixel_in = p; mode_in = md; last_col_in = lc; last_pic_in = lp; valid_in = 1'b1;
    e = cyc + 1;
  endtask

  task automatic beat_end();
    @(negedge clk);
    valid_in = 1'b0; pixel_in = '0; last_col_in = 1'b0; last_pic_in = 1'b0;
  endtask

  // 4x2 picture. q holds hand-computed demosaic outputs R0,G0,B0,R1,G1,B1.
  task automatic pic4x2(input logic [7:0] px [8], input logic [2:0] md [8], input logic dem,
                        input logic [7:0] q [6], output int e_last);
    int e;
    e_last = 0;
    for (int i = 0; i < 8; i++) begin
      beat_start(px[i], md[i], (i == 3) || (i == 7), i == 7, e);
      if (!dem) begin
        expect_out(px[i], BYP_COL[i], (i == 3) || (i == 7), i == 7, e);
      end else if (i == 5) begin
        expect_out(q[0], 2'd1, 1'b0, 1'b0, e);
        expect_out(q[1], 2'd2, 1'b0, 1'b0, e + 1);
        expect_out(q[2], 2'd3, 1'b0, 1'b0, e + 2);
      end else if (i == 7) begin
        expect_out(q[3], 2'd1, 1'b0, 1'b0, e);
        expect_out(q[4], 2'd2, 1'b0, 1'b0, e + 1);
        expect_out(q[5], 2'd3, 1'b1, 1'b1, e + 2);
      end
      beat_end();
      if (i == 0) check("finish_clear_on_start", 64'(finish_operation), 64'd0);
      e_last = e;
    end
  endtask

  // Bounded wait for finish_operation; reports the cycle it was first seen high.
  task automatic wait_finish(input int exp_cyc);
    int got;
    got = -1;
    for (int k = 0; k < 20; k++) begin
      if (finish_operation) begin
        got = cyc;
        break;
      end
      @(negedge clk);
    end
    check("finish_rise_cycle", 64'(got), 64'(exp_cyc));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] px [8];
    logic [2:0] md [8];
    logic [7:0] q [6];
    int e;

    rst_n = 1'b0; valid_in = 1'b0; pixel_in = '0; color_in = '0;
    last_col_in = 1'b0; last_pic_in = 1'b0; mode_in = '0;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_pixel_out", 64'(pixel_out), 64'd0);
    check("rst_color_out", 64'(color_out), 64'd0);
    check("rst_last_flags", 64'({last_col_out, last_pic_out}), 64'd0);
    check("rst_finish", 64'(finish_operation), 64'd0);
    rst_n = 1'b1;

    // BYPASS 4x2
    px = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    md = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    q  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    pic4x2(px, md, 1'b0, q, e);
    check("bypass_finish_not_early", 64'(finish_operation), 64'd0);
    wait_finish(e + 1);

    // DEMOSAIC, same image: (10,35,60) and (30,55,80)
    md = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    q  = '{8'd10, 8'd35, 8'd60, 8'd30, 8'd55, 8'd80};
    pic4x2(px, md, 1'b1, q, e);
    wait_finish(e + 3);

    // Rounding / overflow: (255+254+1)>>1=255, (0+1+1)>>1=1
    px = '{8'd11, 8'd255, 8'd12, 8'd0, 8'd254, 8'd21, 8'd1, 8'd22};
    q  = '{8'd11, 8'd255, 8'd21, 8'd12, 8'd1, 8'd22};
    pic4x2(px, md, 1'b1, q, e);
    wait_finish(e + 3);

    // Mode latch: mode drops to 0 mid-picture, picture stays DEMOSAIC
    px = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    md = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    q  = '{8'd10, 8'd35, 8'd60, 8'd30, 8'd55, 8'd80};
    pic4x2(px, md, 1'b1, q, e);
    wait_finish(e + 3);
    // Next picture relatches BYPASS
    px = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    md = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    pic4x2(px, md, 1'b0, q, e);
    wait_finish(e + 1);

    // Mid-picture reset after 3 demosaic samples (even row: no output)
    beat_start(8'd99, 3'd1, 1'b0, 1'b0, e); beat_end();
    beat_start(8'd98, 3'd1, 1'b0, 1'b0, e); beat_end();
    beat_start(8'd97, 3'd1, 1'b0, 1'b0, e); beat_end();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("no_pending_at_reset", 64'(sb.size()), 64'd0);
    rst_n = 1'b1;
    check("post_reset_finish", 64'(finish_operation), 64'd0);
    px = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    md = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    q  = '{8'd10, 8'd35, 8'd60, 8'd30, 8'd55, 8'd80};
    pic4x2(px, md, 1'b1, q, e);
    wait_finish(e + 3);

    // Odd row count: one even row in DEMOSAIC, no output, DONE one cycle after last_pic_in
    beat_start(8'd1, 3'd1, 1'b0, 1'b0, e); beat_end();
    check("finish_clear_odd_rows", 64'(finish_operation), 64'd0);
    beat_start(8'd2, 3'd1, 1'b0, 1'b0, e); beat_end();
    beat_start(8'd3, 3'd1, 1'b0, 1'b0, e); beat_end();
    beat_start(8'd4, 3'd1, 1'b1, 1'b1, e); beat_end();
    wait_finish(e + 1);

    // Reserved mode 5 behaves as BYPASS, 2x2 picture: R G / G B
    beat_start(8'd7, 3'd5, 1'b0, 1'b0, e); expect_out(8'd7, 2'd1, 1'b0, 1'b0, e); beat_end();
    beat_start(8'd8, 3'd5, 1'b1, 1'b0, e); expect_out(8'd8, 2'd2, 1'b1, 1'b0, e); beat_end();
    beat_start(8'd9, 3'd5, 1'b0, 1'b0, e); expect_out(8'd9, 2'd2, 1'b0, 1'b0, e); beat_end();
    beat_start(8'd6, 3'd5, 1'b1, 1'b1, e); expect_out(8'd6, 2'd3, 1'b1, 1'b1, e); beat_end();
    wait_finish(e + 1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
